ez8_uart: RTL and testbench
===========================

Name: ez8_uart

Overview:
- UART peripheral on the ez8 IO register bus, directly downstream of the memory controller's IO port.
- Decodes 4 of the 32 IO register addresses ({bank[1:0], offset[2:0]}); write-side effects are qualified by io_write_en.
- Returns registered read data one cycle after io_readaddr is presented, matching the controller's registered-address read path.
- Drives level interrupt lines into io_interrupts. Provides 8N1 serial TX/RX, each with a small FIFO.

Parameters:
BASE_ADDR, 5'd8, IO address of register 0; must be 4-aligned; block occupies BASE..BASE+3
FIFO_DEPTH, 4, entries in each of TX and RX FIFO; power of two, >=2
DIV_RESET, 16'd433, reset value of baud divisor (bit period = DIV+1 clk cycles)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pause  in  1  pipeline stall; when high, bus writes ignored and io_readdata holds
io_readaddr  in  5  IO read address
io_readdata  out  8  registered read data; 0 when previous-cycle address unmapped
io_writeaddr  in  5  IO write address
io_writedata  in  8  IO write data
io_write_en  in  1  IO write strobe
uart_rxd  in  1  serial input, asynchronous
uart_txd  out  1  serial output
irq_rx  out  1  level: RX FIFO non-empty
irq_tx  out  1  level: TX FIFO empty and TX idle

Behaviour:
- Reset values: io_readdata=0, uart_txd=1, irq_rx=0, irq_tx=1, both FIFOs empty, error flags 0, DIV=DIV_RESET, TX/RX FSMs IDLE, rxd synchronizer flops=1.
- Register map (offset from BASE):
  - 0 DATA: write pushes TX FIFO; read returns RX head without popping.
  - 1 STATUS: read {0, frame_err, overrun, tx_busy, tx_empty, tx_full, rx_full, rx_valid}. Write is W1 action: bit0=1 pops RX if non-empty; bit5=1 clears overrun; bit6=1 clears frame_err.
  - 2 DIVLO, 3 DIVHI: read/write divisor bytes.
- Read: when !pause, io_readdata <= mux(io_readaddr) on every clk. Reads have no side effects. A read and a write in the same cycle return pre-write state.
- Write: takes effect when io_write_en && !pause && io_writeaddr in range.
- TX FIFO push:
  - Accepted if not full, or if the TX FSM pops in the same cycle.
  - Otherwise dropped silently; no flag.
- TX FSM IDLE/START/DATA/STOP:
  - IDLE: if FIFO non-empty, pop into shift reg and go START.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1. Each state lasts DIV+1 cycles.
  - After STOP, return to IDLE; the next byte may start on the following cycle.
  - tx_busy=1 in all states except IDLE.
- RX input: 2-flop synchronizer on uart_rxd; a falling edge is sync_prev=1 and sync=0.
- RX FSM IDLE/START/DATA/STOP:
  - IDLE: on falling edge, go START.
  - START: wait (DIV+1)>>1 cycles, sample. If 1 (glitch), go IDLE; else go DATA.
  - DATA: sample every DIV+1 cycles, 8 bits LSB first.
  - STOP: sample after DIV+1 cycles.
    - Stop bit 1: push byte to RX FIFO.
    - Stop bit 0: discard byte, set frame_err.
  - Return to IDLE; a new frame requires a fresh falling edge.
- RX push when full:
  - If a software pop occurs the same cycle, both the push and the pop happen.
  - Otherwise the byte is dropped and overrun is set.
- Flag priority: error set wins over a same-cycle W1 clear.
- Divisor: counters are 16-bit. A divisor write mid-frame takes effect at the next bit-period reload. RX requires DIV>=3; TX is correct for any DIV.
- FIFO pointers wrap modulo FIFO_DEPTH and use an extra wrap bit for full/empty.
- irq_rx = rx_valid; irq_tx = tx_empty && !tx_busy. Both are combinational from registered state.
- Reset mid-frame: aborts immediately. uart_txd=1 on the next cycle; FIFO contents lost.

Test Plan:
- Reset, then read STATUS at BASE+1 -> io_readdata=8'h08 one cycle later; read DIVLO/DIVHI -> 8'hB1/8'h01; uart_txd=1, irq_tx=1.
- DIV=3, write 8'hA5 to DATA -> uart_txd shows start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit exactly 4 cycles; tx_busy=1 throughout; irq_tx returns to 1 after stop.
- DIV=3, drive rxd frame 8'h3C -> rx_valid=1, irq_rx=1. DATA reads 8'h3C twice (no pop). Write STATUS 8'h01 -> rx_valid=0.
- Send FIFO_DEPTH+1 frames with no pops -> first 4 bytes retained in order, overrun=1. Write STATUS 8'h20 -> overrun=0.
- Frame with stop bit 0 -> FIFO unchanged, frame_err=1. Also: 1-cycle low glitch on rxd -> nothing received.
- Push 5 bytes rapidly -> first byte goes to shifter, 4 queued, tx_full=1. A 6th push while tx_full=1 is dropped. With pause=1, a write to DATA is ignored and io_readdata holds its value. A read of an unmapped address -> io_readdata=0.

Source files
------------

// File: rtl/ez8_uart.sv
// ez8_uart: UART peripheral on the ez8 IO register bus.
//
// Four registers at BASE_ADDR..BASE_ADDR+3:
//   +0 DATA   write pushes TX FIFO, read returns RX head (no pop)
//   +1 STATUS read {0, frame_err, overrun, tx_busy, tx_empty, tx_full, rx_full, rx_valid}
//             write-1 actions: bit0 pops RX, bit5 clears overrun, bit6 clears frame_err
//   +2 DIVLO  baud divisor low byte  (bit period = DIV+1 clk cycles)
//   +3 DIVHI  baud divisor high byte
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pause             pipeline stall: bus writes ignored, io_readdata holds
//   io_readaddr       read address; io_readdata is registered one cycle later
//   io_writeaddr/data write address/data, qualified by io_write_en
//   uart_rxd          asynchronous serial input (8N1)
//   uart_txd          registered serial output (8N1)
//   irq_rx            level: RX FIFO non-empty
//   irq_tx            level: TX FIFO empty and transmitter idle
module ez8_uart #(
  parameter logic [4:0]  BASE_ADDR  = 5'd8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic [4:0] io_readaddr,
  output logic [7:0] io_readdata,
  input  logic [4:0] io_writeaddr,
  input  logic [7:0] io_writedata,
  input  logic       io_write_en,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       irq_rx,
  output logic       irq_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Register state
  logic [15:0] div_r;
  logic        overrun_r;
  logic        frame_err_r;

  // TX FIFO and transmitter
  logic [7:0]  tx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr_r;
  logic [AW:0] tx_rd_ptr_r;
  uart_state_e tx_state_r;
  logic [15:0] tx_cnt_r;
  logic [7:0]  tx_shift_r;
  logic [2:0]  tx_bit_r;

  // RX synchronizer, receiver and FIFO
  logic        rx_meta_r;
  logic        rx_sync_r;
  logic        rx_prev_r;
  uart_state_e rx_state_r;
  logic [15:0] rx_cnt_r;
  logic [7:0]  rx_shift_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_mem_r [FIFO_DEPTH];
  logic [AW:0] rx_wr_ptr_r;
  logic [AW:0] rx_rd_ptr_r;

  // Combinational decode and status
  logic        wr_hit_s;
  logic        wr_data_s;
  logic        wr_stat_s;
  logic        wr_divlo_s;
  logic        wr_divhi_s;
  logic        tx_empty_s;
  logic        tx_full_s;
  logic        tx_busy_s;
  logic        tx_pop_s;
  logic        tx_push_s;
  logic        rx_valid_s;
  logic        rx_full_s;
  logic        rx_pop_s;
  logic        rx_stop_done_s;
  logic        rx_push_req_s;
  logic        rx_push_s;
  logic        overrun_set_s;
  logic        frame_err_set_s;
  logic        rx_fall_s;
  logic [15:0] rx_half_s;
  logic [7:0]  status_s;
  logic [7:0]  rd_mux_s;

  // Block is 4-aligned, so the upper three address bits select it and the low two pick the register.
  assign wr_hit_s   = io_write_en && !pause && (io_writeaddr[4:2] == BASE_ADDR[4:2]);
  assign wr_data_s  = wr_hit_s && (io_writeaddr[1:0] == 2'd0);
  assign wr_stat_s  = wr_hit_s && (io_writeaddr[1:0] == 2'd1);
  assign wr_divlo_s = wr_hit_s && (io_writeaddr[1:0] == 2'd2);
  assign wr_divhi_s = wr_hit_s && (io_writeaddr[1:0] == 2'd3);

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
  assign tx_full_s  = (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]) &&
                      (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]);
  assign tx_busy_s  = (tx_state_r != ST_IDLE);
  assign tx_pop_s   = (tx_state_r == ST_IDLE) && !tx_empty_s;
  // A full FIFO still accepts a push when the transmitter drains an entry in the same cycle.
  assign tx_push_s  = wr_data_s && (!tx_full_s || tx_pop_s);

  assign rx_valid_s = (rx_wr_ptr_r != rx_rd_ptr_r);
  assign rx_full_s  = (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]) &&
                      (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]);
  assign rx_pop_s   = wr_stat_s && io_writedata[0] && rx_valid_s;

  assign rx_fall_s       = rx_prev_r && !rx_sync_r;
  assign rx_stop_done_s  = (rx_state_r == ST_STOP) && (rx_cnt_r == 16'd0);
  assign rx_push_req_s   = rx_stop_done_s && rx_sync_r;
  assign frame_err_set_s = rx_stop_done_s && !rx_sync_r;
  assign rx_push_s       = rx_push_req_s && (!rx_full_s || rx_pop_s);
  assign overrun_set_s   = rx_push_req_s && rx_full_s && !rx_pop_s;

  // Half bit period minus one, i.e. ((DIV+1)>>1)-1, without a 17-bit intermediate.
  assign rx_half_s = {1'b0, div_r[15:1]} - {15'd0, ~div_r[0]};

  assign status_s = {1'b0, frame_err_r, overrun_r, tx_busy_s, tx_empty_s,
                     tx_full_s, rx_full_s, rx_valid_s};

  assign irq_rx = rx_valid_s;
  assign irq_tx = tx_empty_s && !tx_busy_s;

  // Read data multiplexer; unmapped addresses return zero.
  always_comb begin
    rd_mux_s = 8'd0;
    if (io_readaddr[4:2] == BASE_ADDR[4:2]) begin
      case (io_readaddr[1:0])
        2'd0:    rd_mux_s = rx_mem_r[rx_rd_ptr_r[AW-1:0]];
        2'd1:    rd_mux_s = status_s;
        2'd2:    rd_mux_s = div_r[7:0];
        2'd3:    rd_mux_s = div_r[15:8];
        default: rd_mux_s = 8'd0;
      endcase
    end else begin
      rd_mux_s = 8'd0;
    end
  end

  // Registered read data, held while the pipeline is paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_readdata <= 8'd0;
    end else if (!pause) begin
      io_readdata <= rd_mux_s;
    end
  end

  // Baud divisor register bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= DIV_RESET;
    end else begin
      if (wr_divlo_s) div_r[7:0]  <= io_writedata;
      if (wr_divhi_s) div_r[15:8] <= io_writedata;
    end
  end

  // Sticky error flags; a same-cycle set beats a write-1 clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (overrun_set_s)                         overrun_r <= 1'b1;
      else if (wr_stat_s && io_writedata[5])     overrun_r <= 1'b0;
      if (frame_err_set_s)                       frame_err_r <= 1'b1;
      else if (wr_stat_s && io_writedata[6])     frame_err_r <= 1'b0;
    end
  end

  // TX FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= io_writedata;
  end

  // TX FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Transmitter FSM; every non-idle state lasts DIV+1 cycles and uart_txd changes with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_shift_r <= 8'd0;
      tx_bit_r   <= 3'd0;
      uart_txd   <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          if (tx_pop_s) begin
            tx_shift_r <= tx_mem_r[tx_rd_ptr_r[AW-1:0]];
            tx_cnt_r   <= div_r;
            uart_txd   <= 1'b0;
            tx_state_r <= ST_START;
          end else begin
            uart_txd   <= 1'b1;
          end
        end
        ST_START: begin
          if (tx_cnt_r == 16'd0) begin
            tx_cnt_r   <= div_r;
            uart_txd   <= tx_shift_r[0];
            tx_bit_r   <= 3'd0;
            tx_state_r <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_r == 16'd0) begin
            tx_cnt_r <= div_r;
            if (tx_bit_r == 3'd7) begin
              uart_txd   <= 1'b1;
              tx_state_r <= ST_STOP;
            end else begin
              uart_txd   <= tx_shift_r[1];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_bit_r   <= tx_bit_r + 3'd1;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_r == 16'd0) begin
            tx_state_r <= ST_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
          end
        end
        default: begin
          tx_state_r <= ST_IDLE;
          uart_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchronizer for uart_rxd plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rxd;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver FSM; the start bit is re-checked at mid-bit to reject glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_shift_r <= 8'd0;
      rx_bit_r   <= 3'd0;
    end else begin
      case (rx_state_r)
        ST_IDLE: begin
          if (rx_fall_s) begin
            rx_cnt_r   <= rx_half_s;
            rx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_r == 16'd0) begin
            if (rx_sync_r) begin
              rx_state_r <= ST_IDLE;
            end else begin
              rx_cnt_r   <= div_r;
              rx_bit_r   <= 3'd0;
              rx_state_r <= ST_DATA;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_r == 16'd0) begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_cnt_r   <= div_r;
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= ST_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          // Stop-bit evaluation (push or frame error) is decoded combinationally from this state.
          if (rx_cnt_r == 16'd0) begin
            rx_state_r <= ST_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r - 16'd1;
          end
        end
        default: begin
          rx_state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_shift_r;
  end

  // RX FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ez8_uart.sv
// Self-checking bench for ez8_uart: register-access vector table, directed
// serial sequences and a randomized phase checked against a queue-based model.
module tb_ez8_uart;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic [4:0] io_readaddr;
  logic [7:0] io_readdata;
  logic [4:0] io_writeaddr;
  logic [7:0] io_writedata;
  logic       io_write_en;
  logic       uart_rxd;
  logic       uart_txd;
  logic       irq_rx;
  logic       irq_tx;

  always #5 clk = ~clk;

  ez8_uart dut (
    .clk         (clk),
    .reset       (reset),
    .pause       (pause),
    .io_readaddr (io_readaddr),
    .io_readdata (io_readdata),
    .io_writeaddr(io_writeaddr),
    .io_writedata(io_writedata),
    .io_write_en (io_write_en),
    .uart_rxd    (uart_rxd),
    .uart_txd    (uart_txd),
    .irq_rx      (irq_rx),
    .irq_tx      (irq_tx)
  );

  int checks   = 0;
  int failures = 0;
  int per      = 434;          // current bit period in clk cycles (DIV+1)

  // Reference model of the receive side
  logic [7:0] rxq[$];
  logic       m_ovr;
  logic       m_ferr;

  // Bytes decoded from uart_txd by the line monitor
  logic [7:0] tx_seen[$];
  int         tx_stop_err = 0;

  typedef struct {
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       p;
    logic [4:0] raddr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    io_writeaddr = a;
    io_writedata = d;
    io_write_en  = 1'b1;
    tick();
    io_write_en  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    io_readaddr = a;
    tick();
    d = io_readdata;
  endtask

  task automatic set_div(input int p);
    logic [15:0] dv;
    dv = 16'(p - 1);
    wr(5'd10, dv[7:0]);
    wr(5'd11, dv[15:8]);
    per = p;
  endtask

  // Software STATUS write, mirrored in the model.
  task automatic wr_status(input logic [7:0] d);
    wr(5'd9, d);
    if (d[0] && rxq.size() > 0) void'(rxq.pop_front());
    if (d[5]) m_ovr = 1'b0;
    if (d[6]) m_ferr = 1'b0;
  endtask

  // Drive one 8N1 frame on uart_rxd and update the model with its outcome.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (per) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (per) tick();
    end
    uart_rxd = stop_bit;
    repeat (per) tick();
    uart_rxd = 1'b1;
    repeat (2 * per + 4) tick();
    if (!stop_bit)                m_ferr = 1'b1;
    else if (rxq.size() < DEPTH)  rxq.push_back(b);
    else                          m_ovr = 1'b1;
  endtask

  // Compare STATUS, irq_rx and RX head against the model (transmitter assumed idle).
  task automatic check_rx(input string name);
    logic [7:0] s;
    logic [7:0] e;
    e = {1'b0, m_ferr, m_ovr, 1'b0, 1'b1, 1'b0, rxq.size() == DEPTH, rxq.size() != 0};
    rd(5'd9, s);
    chk({name, "_status"}, 16'(s), 16'(e));
    chk({name, "_irq_rx"}, 16'(irq_rx), 16'(rxq.size() != 0));
    if (rxq.size() > 0) begin
      rd(5'd8, s);
      chk({name, "_head"}, 16'(s), 16'(rxq[0]));
    end
  endtask

  task automatic expect_tx(input logic [7:0] e, input string name);
    int n;
    logic [7:0] got;
    n = 0;
    while (tx_seen.size() == 0 && n < 1000) begin
      tick();
      n++;
    end
    if (tx_seen.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no frame seen on uart_txd, expected %0h", name, e);
    end else begin
      got = tx_seen.pop_front();
      chk(name, 16'(got), 16'(e));
    end
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (irq_tx !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("tx_idle_wait", 16'(irq_tx), 16'd1);
  endtask

  // Line monitor: decodes 8N1 frames from uart_txd by mid-bit sampling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset === 1'b0 && uart_txd === 1'b0) begin
        logic [7:0] b;
        int p;
        p = per;
        b = 8'd0;
        repeat (p / 2) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
          repeat (p) begin @(posedge clk); #1; end
          b[i] = uart_txd;
        end
        repeat (p) begin @(posedge clk); #1; end
        if (uart_txd !== 1'b1) tx_stop_err++;
        tx_seen.push_back(b);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic [9:0] fr;
    logic [7:0] ob[5];
    logic [7:0] tb5[6];
    int a;

    // we waddr   wdata  pause raddr  expected io_readdata
    vecs[0]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd9,  8'h08};
    vecs[1]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd10, 8'hB1};
    vecs[2]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd11, 8'h01};
    vecs[3]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00};
    vecs[4]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd12, 8'h00};
    vecs[5]  = '{1'b1, 5'd10, 8'h03, 1'b0, 5'd10, 8'hB1};
    vecs[6]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd10, 8'h03};
    vecs[7]  = '{1'b1, 5'd11, 8'h00, 1'b0, 5'd11, 8'h01};
    vecs[8]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd11, 8'h00};
    vecs[9]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd10, 8'h03};
    vecs[10] = '{1'b1, 5'd10, 8'h77, 1'b1, 5'd9,  8'h03};
    vecs[11] = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd10, 8'h03};
    vecs[12] = '{1'b1, 5'd14, 8'h55, 1'b0, 5'd10, 8'h03};
    vecs[13] = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd7,  8'h00};
    vecs[14] = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd9,  8'h08};

    ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33; ob[3] = 8'h44; ob[4] = 8'h55;
    tb5[0] = 8'hC1; tb5[1] = 8'hC2; tb5[2] = 8'hC3; tb5[3] = 8'hC4; tb5[4] = 8'hC5; tb5[5] = 8'hC6;

    reset = 1'b1; pause = 1'b0; io_write_en = 1'b0;
    io_writeaddr = 5'd0; io_writedata = 8'd0; io_readaddr = 5'd0; uart_rxd = 1'b1;
    m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("reset_txd", 16'(uart_txd), 16'd1);
    chk("reset_irq_tx", 16'(irq_tx), 16'd1);
    chk("reset_irq_rx", 16'(irq_rx), 16'd0);
    chk("reset_readdata", 16'(io_readdata), 16'd0);

    // Register access table (leaves DIV=3)
    for (int i = 0; i < 15; i++) begin
      io_write_en  = vecs[i].we;
      io_writeaddr = vecs[i].waddr;
      io_writedata = vecs[i].wdata;
      pause        = vecs[i].p;
      io_readaddr  = vecs[i].raddr;
      tick();
      chk($sformatf("vec%0d_readdata", i), 16'(io_readdata), 16'(vecs[i].exp));
    end
    io_write_en = 1'b0;
    pause = 1'b0;
    per = 4;

    // TX frame 0xA5 with exact 4-cycle bit timing
    fr = {1'b1, 8'hA5, 1'b0};
    wr(5'd8, 8'hA5);
    for (int s = 0; s < 40; s++) begin
      tick();
      chk($sformatf("tx_a5_sample%0d", s), 16'(uart_txd), 16'(fr[s / 4]));
      chk("tx_a5_irq_tx_low", 16'(irq_tx), 16'd0);
    end
    tick();
    chk("tx_a5_txd_idle", 16'(uart_txd), 16'd1);
    chk("tx_a5_irq_tx_back", 16'(irq_tx), 16'd1);
    expect_tx(8'hA5, "tx_a5_decoded");

    // RX frame 0x3C, non-destructive DATA reads, then pop
    send_rx(8'h3C, 1'b1);
    check_rx("rx3c");
    rd(5'd8, d); chk("rx3c_read1", 16'(d), 16'h3C);
    rd(5'd8, d); chk("rx3c_read2", 16'(d), 16'h3C);
    wr_status(8'h01);
    rd(5'd9, d); chk("rx3c_popped_status", 16'(d), 16'h08);
    check_rx("rx3c_pop");

    // Overrun: FIFO_DEPTH+1 frames without pops
    for (int i = 0; i < 5; i++) send_rx(ob[i], 1'b1);
    check_rx("ovr");
    for (int i = 0; i < 4; i++) begin
      rd(5'd8, d);
      chk($sformatf("ovr_order%0d", i), 16'(d), 16'(ob[i]));
      wr_status(8'h01);
    end
    rd(5'd9, d); chk("ovr_flag", 16'(d), 16'h28);
    wr_status(8'h20);
    rd(5'd9, d); chk("ovr_cleared", 16'(d), 16'h08);

    // Frame error and glitch rejection
    send_rx(8'h99, 1'b0);
    rd(5'd9, d); chk("ferr_flag", 16'(d), 16'h48);
    check_rx("ferr");
    wr_status(8'h40);
    check_rx("ferr_clear");
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    repeat (20) tick();
    check_rx("glitch");

    // TX FIFO fill: 5 rapid pushes, 6th dropped
    for (int i = 0; i < 6; i++) wr(5'd8, tb5[i]);
    rd(5'd9, d);
    chk("txfull_busy_empty_full", 16'(d[4:2]), 16'(3'b101));
    for (int i = 0; i < 5; i++) expect_tx(tb5[i], $sformatf("txfull_frame%0d", i));
    wait_tx_idle();
    repeat (100) tick();
    chk("txfull_sixth_dropped", 16'(tx_seen.size()), 16'd0);

    // Paused DATA write is ignored
    pause = 1'b1;
    wr(5'd8, 8'h5A);
    pause = 1'b0;
    repeat (60) tick();
    chk("pause_no_frame", 16'(tx_seen.size()), 16'd0);
    chk("pause_irq_tx", 16'(irq_tx), 16'd1);

    // Randomized mix against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) set_div($urandom_range(4, 8));
      a = $urandom_range(0, 5);
      b = 8'($urandom);
      case (a)
        0, 1, 2: send_rx(b, $urandom_range(0, 4) != 0);
        3:       wr_status(8'h01);
        4:       wr_status(b & 8'h61);
        default: begin
          wr(5'd8, b);
          expect_tx(b, $sformatf("rand_tx%0d", it));
          wait_tx_idle();
        end
      endcase
      check_rx($sformatf("rand%0d", it));
    end
    chk("tx_stop_bits", 16'(tx_stop_err), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
